// File: rtl/gear_shift_controller.sv
// Transmission controller: NEUTRAL/DRIVE/SHIFT/HOLD sequencing on the 10 Hz tick.
// Automatic threshold shifting or guarded manual shifting with timed shift and holdoff.
module gear_shift_controller #(
  parameter int UPSHIFT_RPM    = 5000,
  parameter int DOWNSHIFT_RPM  = 1500,
  parameter int DOWN_GUARD_RPM = 4000,
  parameter int SHIFT_TICKS    = 3,
  parameter int HOLDOFF_TICKS  = 5,
  parameter int MAX_GEAR       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_10hz,
  input  logic [13:0] rpm,
  input  logic [8:0]  speed_kmh,
  input  logic        throttle,
  input  logic        brake,
  input  logic        auto_en,
  input  logic        manual_up,
  input  logic        manual_dn,
  output logic [2:0]  gear,
  output logic        shifting,
  output logic        shift_up_evt,
  output logic        shift_dn_evt
);

  typedef enum logic [1:0] {
    S_NEUTRAL,
    S_DRIVE,
    S_SHIFT,
    S_HOLD
  } state_e;

  localparam logic [13:0] UP_TH    = 14'(UPSHIFT_RPM);
  localparam logic [13:0] DN_TH    = 14'(DOWNSHIFT_RPM);
  localparam logic [13:0] GUARD_TH = 14'(DOWN_GUARD_RPM);
  localparam logic [3:0]  SHIFT_N  = 4'(SHIFT_TICKS);
  localparam logic [3:0]  HOLD_N   = 4'(HOLDOFF_TICKS);
  localparam logic [2:0]  TOP_GEAR = 3'(MAX_GEAR);

  state_e      state_q, state_d;
  logic [2:0]  gear_q, gear_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_up_q, dir_up_d;
  logic        pend_up_q, pend_up_d;
  logic        pend_dn_q, pend_dn_d;
  logic        up_evt_q, up_evt_d;
  logic        dn_evt_q, dn_evt_d;

  logic can_up;
  logic can_dn;
  logic drive_tick;

  assign can_up     = gear_q < TOP_GEAR;
  assign can_dn     = gear_q > 3'd1;
  assign drive_tick = tick_10hz && (state_q == S_DRIVE);

  always_comb begin
    state_d   = state_q;
    gear_d    = gear_q;
    cnt_d     = cnt_q;
    dir_up_d  = dir_up_q;
    up_evt_d  = 1'b0;
    dn_evt_d  = 1'b0;
    pend_up_d = 1'b0;
    pend_dn_d = 1'b0;

    // Requests only accumulate while driving manually; a DRIVE tick consumes them.
    if (state_q == S_DRIVE && !auto_en) begin
      pend_up_d = drive_tick ? manual_up : (pend_up_q | manual_up);
      pend_dn_d = drive_tick ? manual_dn : (pend_dn_q | manual_dn);
    end

    if (tick_10hz) begin
      unique case (state_q)
        S_NEUTRAL: begin
          gear_d = 3'd0;
          if (throttle && !brake) begin
            gear_d  = 3'd1;
            cnt_d   = HOLD_N;
            state_d = S_HOLD;
          end
        end
        S_DRIVE: begin
          if (speed_kmh == 9'd0 && !throttle) begin
            gear_d  = 3'd0;
            state_d = S_NEUTRAL;
          end else if (auto_en) begin
            if (rpm >= UP_TH && throttle && can_up) begin
              dir_up_d = 1'b1;
              cnt_d    = SHIFT_N;
              state_d  = S_SHIFT;
            end else if (rpm <= DN_TH && can_dn) begin
              dir_up_d = 1'b0;
              cnt_d    = SHIFT_N;
              state_d  = S_SHIFT;
            end
          end else if (pend_up_q && pend_dn_q) begin
            state_d = S_DRIVE;
          end else if (pend_up_q && can_up) begin
            dir_up_d = 1'b1;
            cnt_d    = SHIFT_N;
            state_d  = S_SHIFT;
          end else if (pend_dn_q && can_dn && rpm < GUARD_TH) begin
            dir_up_d = 1'b0;
            cnt_d    = SHIFT_N;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            if (dir_up_q && can_up) begin
              gear_d   = gear_q + 3'd1;
              up_evt_d = 1'b1;
            end else if (!dir_up_q && can_dn) begin
              gear_d   = gear_q - 3'd1;
              dn_evt_d = 1'b1;
            end
            cnt_d   = HOLD_N;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = S_DRIVE;
          end
        end
        default: begin
          gear_d  = 3'd0;
          cnt_d   = 4'd0;
          state_d = S_NEUTRAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_NEUTRAL;
      gear_q    <= 3'd0;
      cnt_q     <= 4'd0;
      dir_up_q  <= 1'b0;
      pend_up_q <= 1'b0;
      pend_dn_q <= 1'b0;
      up_evt_q  <= 1'b0;
      dn_evt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gear_q    <= gear_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      up_evt_q  <= up_evt_d;
      dn_evt_q  <= dn_evt_d;
    end
  end

  assign gear         = gear_q;
  assign shifting     = (state_q == S_SHIFT);
  assign shift_up_evt = up_evt_q;
  assign shift_dn_evt = dn_evt_q;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller: engage, auto/manual shifts,
// top-gear limit, neutral return and asynchronous reset mid-shift.
module tb_gear_shift_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_10hz = 1'b0;
  logic [13:0] rpm = 14'd0;
  logic [8:0]  speed_kmh = 9'd0;
  logic        throttle = 1'b0;
  logic        brake = 1'b0;
  logic        auto_en = 1'b1;
  logic        manual_up = 1'b0;
  logic        manual_dn = 1'b0;
  logic [2:0]  gear;
  logic        shifting;
  logic        shift_up_evt;
  logic        shift_dn_evt;

  int n_checks = 0;
  int n_fail = 0;
  int up_cnt = 0;
  int dn_cnt = 0;

  gear_shift_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_10hz(tick_10hz),
    .rpm(rpm), .speed_kmh(speed_kmh),
    .throttle(throttle), .brake(brake), .auto_en(auto_en),
    .manual_up(manual_up), .manual_dn(manual_dn),
    .gear(gear), .shifting(shifting),
    .shift_up_evt(shift_up_evt), .shift_dn_evt(shift_dn_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (shift_up_evt) up_cnt <= up_cnt + 1;
    if (shift_dn_evt) dn_cnt <= dn_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_tick();
    @(negedge clk) tick_10hz = 1'b1;
    @(negedge clk) tick_10hz = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_dn();
    @(negedge clk) manual_dn = 1'b1;
    @(negedge clk) manual_dn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (gear !== 3'd0) begin
      n_fail++; $display("FAIL reset_gear: got %0d want 0", gear);
    end
    n_checks++;
    if (shifting !== 1'b0 || shift_up_evt !== 1'b0 || shift_dn_evt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b want 000",
               shifting, shift_up_evt, shift_dn_evt);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_engage();
    auto_en = 1'b1; throttle = 1'b1; brake = 1'b0;
    rpm = 14'd900; speed_kmh = 9'd0;
    do_tick();
    n_checks++;
    if (gear !== 3'd1) begin
      n_fail++; $display("FAIL engage_gear: got %0d want 1", gear);
    end
    rpm = 14'd5200;
    do_ticks(5);
    n_checks++;
    if (shifting !== 1'b0 || gear !== 3'd1) begin
      n_fail++;
      $display("FAIL engage_hold: got shifting=%b gear=%0d want 0/1", shifting, gear);
    end
    n_checks++;
    if (up_cnt != 0 || dn_cnt != 0) begin
      n_fail++; $display("FAIL engage_evt: got up=%0d dn=%0d want 0/0", up_cnt, dn_cnt);
    end
  endtask

  task automatic test_auto_up();
    speed_kmh = 9'd40;
    do_tick();
    n_checks++;
    if (shifting !== 1'b1 || gear !== 3'd1) begin
      n_fail++;
      $display("FAIL auto_up_start: got shifting=%b gear=%0d want 1/1", shifting, gear);
    end
    do_ticks(2);
    n_checks++;
    if (shifting !== 1'b1 || gear !== 3'd1) begin
      n_fail++;
      $display("FAIL auto_up_mid: got shifting=%b gear=%0d want 1/1", shifting, gear);
    end
    do_tick();
    n_checks++;
    if (gear !== 3'd2 || shift_up_evt !== 1'b1 || shifting !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_up_done: got gear=%0d evt=%b shifting=%b want 2/1/0",
               gear, shift_up_evt, shifting);
    end
    @(negedge clk);
    n_checks++;
    if (shift_up_evt !== 1'b0) begin
      n_fail++; $display("FAIL auto_up_pulse: got %b want 0", shift_up_evt);
    end
  endtask

  task automatic test_top_gear();
    int n;
    bit saw_shift;
    n = 0;
    while (gear !== 3'd6 && n < 100) begin
      do_tick();
      n++;
    end
    n_checks++;
    if (gear !== 3'd6) begin
      n_fail++; $display("FAIL top_reach: got %0d want 6", gear);
    end
    do_ticks(5);
    rpm = 14'd6000;
    saw_shift = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (shifting) saw_shift = 1'b1;
    end
    n_checks++;
    if (gear !== 3'd6 || saw_shift) begin
      n_fail++;
      $display("FAIL top_hold: got gear=%0d saw_shift=%b want 6/0", gear, saw_shift);
    end
    n_checks++;
    if (up_cnt != 5) begin
      n_fail++; $display("FAIL top_evt_count: got %0d want 5", up_cnt);
    end
  endtask

  task automatic test_manual();
    auto_en = 1'b0; rpm = 14'd2000;
    for (int i = 0; i < 3; i++) begin
      pulse_dn();
      do_ticks(9);
    end
    n_checks++;
    if (gear !== 3'd3 || dn_cnt != 3) begin
      n_fail++; $display("FAIL manual_to3: got gear=%0d dn=%0d want 3/3", gear, dn_cnt);
    end
    @(negedge clk) begin manual_up = 1'b1; manual_dn = 1'b1; end
    @(negedge clk) begin manual_up = 1'b0; manual_dn = 1'b0; end
    do_tick();
    n_checks++;
    if (shifting !== 1'b0) begin
      n_fail++; $display("FAIL manual_both: got shifting=%b want 0", shifting);
    end
    do_ticks(4);
    n_checks++;
    if (gear !== 3'd3) begin
      n_fail++; $display("FAIL manual_both_gear: got %0d want 3", gear);
    end
    rpm = 14'd4500;
    pulse_dn();
    do_tick();
    n_checks++;
    if (shifting !== 1'b0) begin
      n_fail++; $display("FAIL manual_guard: got shifting=%b want 0", shifting);
    end
    rpm = 14'd2000;
    do_ticks(4);
    n_checks++;
    if (gear !== 3'd3 || shifting !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_discard: got gear=%0d shifting=%b want 3/0", gear, shifting);
    end
    pulse_dn();
    do_tick();
    n_checks++;
    if (shifting !== 1'b1) begin
      n_fail++; $display("FAIL manual_dn_start: got shifting=%b want 1", shifting);
    end
    do_ticks(2);
    n_checks++;
    if (gear !== 3'd3) begin
      n_fail++; $display("FAIL manual_dn_mid: got %0d want 3", gear);
    end
    do_tick();
    n_checks++;
    if (gear !== 3'd2 || shift_dn_evt !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_dn_done: got gear=%0d evt=%b want 2/1", gear, shift_dn_evt);
    end
    @(negedge clk);
    n_checks++;
    if (shift_dn_evt !== 1'b0) begin
      n_fail++; $display("FAIL manual_dn_pulse: got %b want 0", shift_dn_evt);
    end
    do_ticks(5);
  endtask

  task automatic test_neutral();
    speed_kmh = 9'd0; throttle = 1'b0;
    do_tick();
    n_checks++;
    if (gear !== 3'd0) begin
      n_fail++; $display("FAIL neutral_enter: got %0d want 0", gear);
    end
    throttle = 1'b1; brake = 1'b1;
    do_tick();
    n_checks++;
    if (gear !== 3'd0) begin
      n_fail++; $display("FAIL neutral_brake: got %0d want 0", gear);
    end
    brake = 1'b0;
    do_tick();
    n_checks++;
    if (gear !== 3'd1) begin
      n_fail++; $display("FAIL neutral_engage: got %0d want 1", gear);
    end
  endtask

  task automatic test_reset_mid_shift();
    auto_en = 1'b1; speed_kmh = 9'd50; rpm = 14'd5200; throttle = 1'b1;
    do_ticks(5);
    do_tick();
    n_checks++;
    if (shifting !== 1'b1) begin
      n_fail++; $display("FAIL rst_shift_start: got shifting=%b want 1", shifting);
    end
    do_tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gear !== 3'd0 || shifting !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got gear=%0d shifting=%b want 0/0", gear, shifting);
    end
    do_ticks(3);
    n_checks++;
    if (gear !== 3'd0 || shifting !== 1'b0 || shift_up_evt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held: got gear=%0d shifting=%b evt=%b want 0/0/0",
               gear, shifting, shift_up_evt);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_engage();
    test_auto_up();
    test_top_gear();
    test_manual();
    test_neutral();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
